// File: rtl/param_report_seq.sv
// param_report_seq: serialises the build-time parameter set into a 17-byte
// framed stream (sync, tag/value pairs, XOR checksum) over valid/ready.
// Frames start on start_i or, with PERIOD>0, automatically after each frame.
module param_report_seq #(
  parameter bit          BOO    = 1'b0,
  parameter int          INT    = 0,
  parameter logic        LOG    = 1'b0,
  parameter logic [7:0]  VEC    = 8'd0,
  parameter logic [31:0] STR    = "ABCD",
  parameter real         REA    = 0.0,
  parameter int          PERIOD = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [4:0] count_o
);

  typedef enum logic [2:0] {IDLE, SYNC, TAG, VAL, CSUM, DONE} state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] INT_BYTE  = 8'(INT);
  localparam logic [7:0] REA_BYTE  = (REA == 0.0) ? 8'h00 : 8'h01;
  localparam logic [4:0] LAST_IDX  = 5'd16;

  state_t      state;
  logic [4:0]  idx;
  logic [7:0]  csum;
  logic        abort_pend;
  logic        armed;
  logic [31:0] period_cnt;

  logic        accept;
  logic        abort_now;
  logic        auto_fire;
  logic [4:0]  next_idx;

  // Fixed frame content for byte positions 0..15; position 16 is the checksum.
  function automatic logic [7:0] frame_byte(input logic [4:0] i);
    logic [7:0] b;
    case (i)
      5'd0:    b = SYNC_BYTE;
      5'd1:    b = 8'h42;
      5'd2:    b = {7'd0, BOO};
      5'd3:    b = 8'h49;
      5'd4:    b = INT_BYTE;
      5'd5:    b = 8'h4C;
      5'd6:    b = {7'd0, LOG};
      5'd7:    b = 8'h56;
      5'd8:    b = VEC;
      5'd9:    b = 8'h53;
      5'd10:   b = STR[31:24];
      5'd11:   b = STR[23:16];
      5'd12:   b = STR[15:8];
      5'd13:   b = STR[7:0];
      5'd14:   b = 8'h52;
      5'd15:   b = REA_BYTE;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // FSM state that owns a given byte position.
  function automatic state_t state_of(input logic [4:0] i);
    state_t s;
    if (i == 5'd0)                        s = SYNC;
    else if (i == LAST_IDX)               s = CSUM;
    else if (i >= 5'd10 && i <= 5'd13)    s = VAL;
    else if (i == 5'd14)                  s = TAG;
    else if (i == 5'd15)                  s = VAL;
    else if (i[0])                        s = TAG;
    else                                  s = VAL;
    return s;
  endfunction

  // Handshake, abort and periodic-trigger decode.
  always_comb begin
    accept    = valid_o & ready_i;
    abort_now = abort_i | abort_pend;
    auto_fire = (PERIOD > 0) && armed && (period_cnt <= 32'd1);
    next_idx  = idx + 5'd1;
  end

  // Sequencer FSM with registered stream outputs and period counter.
  // The period counter is loaded on the edge that ends a frame and counts
  // down through DONE and IDLE, so the next sync byte appears PERIOD cycles
  // after done_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      idx        <= '0;
      csum       <= '0;
      abort_pend <= 1'b0;
      armed      <= 1'b0;
      period_cnt <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      count_o    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i || auto_fire) begin
            state      <= SYNC;
            idx        <= '0;
            csum       <= '0;
            abort_pend <= 1'b0;
            armed      <= 1'b0;
            period_cnt <= '0;
            data_o     <= SYNC_BYTE;
            valid_o    <= 1'b1;
            busy_o     <= 1'b1;
            count_o    <= '0;
          end else if (armed) begin
            period_cnt <= period_cnt - 32'd1;
          end
        end
        SYNC, TAG, VAL, CSUM: begin
          if (abort_i) abort_pend <= 1'b1;
          if (accept) begin
            count_o <= count_o + 5'd1;
            if (abort_now || state == CSUM) begin
              state      <= abort_now ? IDLE : DONE;
              done_o     <= !abort_now;
              abort_pend <= 1'b0;
              data_o     <= '0;
              valid_o    <= 1'b0;
              busy_o     <= 1'b0;
              if (PERIOD > 0) begin
                armed      <= 1'b1;
                period_cnt <= 32'(PERIOD);
              end
            end else begin
              idx    <= next_idx;
              state  <= state_of(next_idx);
              csum   <= csum ^ data_o;
              data_o <= (next_idx == LAST_IDX) ? (csum ^ data_o) : frame_byte(next_idx);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (armed) period_cnt <= period_cnt - 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
